// File: rtl/trivium_prng.sv
// trivium_prng: Trivium keystream generator, 32 rounds/clock, 128-bit words on request
module trivium_prng (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] seed,
  input  logic         reseed,
  output logic         reseed_ack,
  output logic [127:0] rdi_data,
  output logic         rdi_valid,
  input  logic         rdi_ready
);
  typedef enum logic [1:0] {UNKEYED, INIT, KEYED, GEN} state_t;
  state_t         st;
  logic [5:0]     cnt;
  logic           pend;
  logic [287:0]   s, s_nx, ld;
  logic [31:0]    z;
  logic [95:0]    acc;
  logic           seed_unused;

  // returns {z, next_state}; bit i of the state vector is Trivium s(i+1)
  function automatic logic [288:0] rnd(input logic [287:0] x);
    logic t1, t2, t3;
    t1 = x[65] ^ x[92];
    t2 = x[161] ^ x[176];
    t3 = x[242] ^ x[287];
    rnd = {t1 ^ t2 ^ t3, 288'b0};
    t1 ^= x[90] & x[91] ^ x[170];
    t2 ^= x[174] & x[175] ^ x[263];
    t3 ^= x[285] & x[286] ^ x[68];
    rnd[287:0] = {x[286:177], t2, x[175:93], t1, x[91:0], t3};
  endfunction

  assign ld = {3'b111, 112'b0, seed[159:80], 13'b0, seed[79:0]};
  assign seed_unused = ^seed[255:160];

  always_comb begin
    s_nx = s;
    z = '0;
    for (int i = 0; i < 32; i++) {z[i], s_nx} = rnd(s_nx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= UNKEYED;
      cnt        <= '0;
      pend       <= 1'b0;
      s          <= '0;
      acc        <= '0;
      rdi_data   <= '0;
      reseed_ack <= 1'b0;
      rdi_valid  <= 1'b0;
    end else begin
      reseed_ack <= 1'b0;
      rdi_valid  <= 1'b0;
      if (rdi_ready && st != KEYED) pend <= 1'b1;
      if (reseed) begin
        s   <= ld;
        st  <= INIT;
        cnt <= '0;
        if (st == GEN) pend <= 1'b1;
      end else if (st == INIT) begin
        s   <= s_nx;
        cnt <= cnt + 6'd1;
        if (cnt == 6'd35) begin
          st         <= KEYED;
          reseed_ack <= 1'b1;
        end
      end else if (st == KEYED && (rdi_ready || pend)) begin
        st   <= GEN;
        cnt  <= '0;
        pend <= 1'b0;
      end else if (st == GEN) begin
        s   <= s_nx;
        acc <= {z, acc[95:32]};
        cnt <= cnt + 6'd1;
        if (cnt == 6'd3) begin
          rdi_data  <= {z, acc};
          rdi_valid <= 1'b1;
          st        <= KEYED;
        end
      end
    end
  end
endmodule
